// File: rtl/upct_encoder_if.sv
// Upper PC table port bundle: BTB-update encode request/response and fetch-side read.
// The master drives requests (BTB/fetch logic); the slave is the table itself.
interface upct_encoder_if #(
  parameter int UPPER_PC_TABLE_ENTRIES     = 8,
  parameter int BTB_TARGET_WIDTH           = 10,
  parameter int LOG_UPPER_PC_TABLE_ENTRIES = $clog2(UPPER_PC_TABLE_ENTRIES),
  parameter int UPPER_PC_WIDTH             = 32 - BTB_TARGET_WIDTH - 1
);
  logic                                  read_req_valid;
  logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] read_req_index;
  logic [UPPER_PC_WIDTH-1:0]             read_resp_upper_PC;

  logic                                  update0_valid;
  logic [31:0]                           update0_target_full_PC;
  logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] update1_upper_PC_index;
  logic                                  update1_hit;

  modport master (
    output read_req_valid, read_req_index, update0_valid, update0_target_full_PC,
    input  read_resp_upper_PC, update1_upper_PC_index, update1_hit
  );

  modport slave (
    input  read_req_valid, read_req_index, update0_valid, update0_target_full_PC,
    output read_resp_upper_PC, update1_upper_PC_index, update1_hit
  );
endinterface

// File: rtl/upct_encoder.sv
// Upper PC table: CAM-encodes target[31:11] into a small index (PLRU replacement) and
// decodes an index back to the upper PC. Optional macro UPCT_WRITE_BYPASS_EN forwards a
// same-cycle miss-allocate to a read of the same index.
module upct_encoder #(
  parameter int UPPER_PC_TABLE_ENTRIES     = 8,
  parameter int BTB_TARGET_WIDTH           = 10,
  parameter int LOG_UPPER_PC_TABLE_ENTRIES = $clog2(UPPER_PC_TABLE_ENTRIES),
  parameter int UPPER_PC_WIDTH             = 32 - BTB_TARGET_WIDTH - 1
) (
  input logic            CLK,
  input logic            nRST,
  upct_encoder_if.slave  bus
);

  localparam int N  = UPPER_PC_TABLE_ENTRIES;
  localparam int IW = LOG_UPPER_PC_TABLE_ENTRIES;
  localparam int UW = UPPER_PC_WIDTH;

  // Table state
  logic [N-1:0]  valid_q;
  logic [UW-1:0] upper_q [N];
  logic [N-2:0]  plru_q;

  // Registered outputs
  logic [UW-1:0] rd_q;
  logic [IW-1:0] idx_q;
  logic          hit_q;

  // Update-side combinational lookup
  logic [UW-1:0] upd_upper;
  logic [N-1:0]  match_vec;
  logic          upd_hit;
  logic          any_free;
  logic [IW-1:0] hit_idx;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] victim_idx;
  logic [IW-1:0] alloc_idx;
  logic [IW-1:0] upd_idx;
  logic [UW-1:0] rd_data;
  logic          unused_low_bits;

  assign upd_upper       = bus.update0_target_full_PC[31:BTB_TARGET_WIDTH+1];
  assign unused_low_bits = ^bus.update0_target_full_PC[BTB_TARGET_WIDTH:0];

  // Walk a way's root-to-leaf path and flip each node to point at the other subtree.
  function automatic logic [N-2:0] plru_touch(input logic [N-2:0] tree,
                                              input logic [IW-1:0] way);
    logic [N-2:0]  t;
    logic [IW-1:0] node;
    logic          b;
    t    = tree;
    node = '0;
    for (int lvl = 0; lvl < IW; lvl++) begin
      b       = way[IW-1-lvl];
      t[node] = ~b;
      node    = IW'(2 * int'(node) + 1 + int'(b));
    end
    return t;
  endfunction

  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    match_vec = '0;
    hit_idx   = '0;
    free_idx  = '0;
    any_free  = 1'b0;
    for (int i = 0; i < N; i++) begin
      match_vec[i] = valid_q[i] && (upper_q[i] == upd_upper);
    end
    // Descending scan so the lowest-numbered candidate is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (match_vec[i]) hit_idx = IW'(i);
      if (!valid_q[i]) begin
        free_idx = IW'(i);
        any_free = 1'b1;
      end
    end
  end

  always_comb begin
    logic [IW-1:0] node;
    victim_idx = '0;
    node       = '0;
    for (int lvl = 0; lvl < IW; lvl++) begin
      victim_idx[IW-1-lvl] = plru_q[node];
      node = IW'(2 * int'(node) + 1 + int'(plru_q[node]));
    end
  end

  assign upd_hit   = |match_vec;
  assign alloc_idx = any_free ? free_idx : victim_idx;
  assign upd_idx   = upd_hit ? hit_idx : alloc_idx;

`ifdef UPCT_WRITE_BYPASS_EN
  logic bypass;
  assign bypass  = bus.read_req_valid && bus.update0_valid && !upd_hit &&
                   (alloc_idx == bus.read_req_index);
  assign rd_data = bypass ? upd_upper : upper_q[bus.read_req_index];
`else
  assign rd_data = upper_q[bus.read_req_index];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, which is what makes the read path read-before-write.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: the table array is reset explicitly because a post-reset read of an
      // unwritten entry must return 0, so it cannot be left as uninitialised RAM.
      valid_q <= '0;
      for (int i = 0; i < N; i++) upper_q[i] <= '0;
      plru_q  <= '0;
      rd_q    <= '0;
      idx_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      if (bus.read_req_valid) rd_q <= rd_data;
      if (bus.update0_valid) begin
        idx_q  <= upd_idx;
        hit_q  <= upd_hit;
        plru_q <= plru_touch(plru_q, upd_idx);
        if (!upd_hit) begin
          valid_q[upd_idx] <= 1'b1;
          upper_q[upd_idx] <= upd_upper;
        end
      end
    end
  end

  assign bus.read_resp_upper_PC     = rd_q;
  assign bus.update1_upper_PC_index = idx_q;
  assign bus.update1_hit            = hit_q;

endmodule

// File: tb/tb_upct_encoder.sv
// Table-driven bench for upct_encoder: vectors carry hand-derived expectations that flow
// through a scoreboard queue, plus a hand-written mid-request asynchronous reset.
module tb_upct_encoder;

  typedef enum logic {K_CYC, K_RST} kind_e;

  typedef struct {
    kind_e       kind;
    logic        rv;
    logic [2:0]  ridx;
    logic        uv;
    logic [31:0] tgt;
    logic [20:0] e_rd;
    logic [2:0]  e_idx;
    logic        e_hit;
  } vec_t;

  typedef struct {
    int          id;
    logic [20:0] rd;
    logic [2:0]  idx;
    logic        hit;
  } exp_t;

`ifdef UPCT_WRITE_BYPASS_EN
  localparam logic [20:0] BYP_RD = 21'h00055;
`else
  localparam logic [20:0] BYP_RD = 21'h00000;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  vec_t vecs[$];
  exp_t sb[$];

  upct_encoder_if bus ();

  upct_encoder dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish within 50000 time units");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] tgt(input logic [20:0] up, input logic [10:0] lo);
    return {up, lo};
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", name, id, act, exp);
    end
  endtask

  task automatic add_rst();
    vec_t v;
    v = '{K_RST, 1'b0, 3'd0, 1'b0, 32'h0, 21'h0, 3'd0, 1'b0};
    vecs.push_back(v);
  endtask

  task automatic add(input logic rv, input logic [2:0] ridx, input logic uv,
                     input logic [31:0] t, input logic [20:0] e_rd,
                     input logic [2:0] e_idx, input logic e_hit);
    vec_t v;
    v = '{K_CYC, rv, ridx, uv, t, e_rd, e_idx, e_hit};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.read_req_valid         = 1'b0;
    bus.read_req_index         = 3'd0;
    bus.update0_valid          = 1'b0;
    bus.update0_target_full_PC = 32'h0;
  endtask

  task automatic check_zero(input int id);
    check("rst_read_resp", id, 32'(bus.read_resp_upper_PC), 32'h0);
    check("rst_index",     id, 32'(bus.update1_upper_PC_index), 32'h0);
    check("rst_hit",       id, 32'(bus.update1_hit), 32'h0);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic apply_reset(input int id);
    drive_idle();
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero(id);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; drives one request cycle and scores the registered result.
  task automatic apply_cycle(input int id, input vec_t v);
    exp_t e;
    exp_t got;
    bus.read_req_valid         = v.rv;
    bus.read_req_index         = v.ridx;
    bus.update0_valid          = v.uv;
    bus.update0_target_full_PC = v.tgt;
    e = '{id, v.e_rd, v.e_idx, v.e_hit};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", id, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check("read_resp", got.id, 32'(bus.read_resp_upper_PC), 32'(got.rd));
      check("index",     got.id, 32'(bus.update1_upper_PC_index), 32'(got.idx));
      check("hit",       got.id, 32'(bus.update1_hit), 32'(got.hit));
    end
    @(negedge clk);
    drive_idle();
  endtask

  // Reset asserted while an update is between request and response edge.
  task automatic midstream_reset(input int id);
    bus.update0_valid          = 1'b1;
    bus.update0_target_full_PC = tgt(21'h77, 11'h0);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_zero(id);
    @(posedge clk);
    #1;
    check_zero(id + 1);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
  endtask

  initial begin
    int step;
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    drive_idle();

    // Basic encode / decode; 0x1800 and 0x1FFE share target[31:11] = 3
    add_rst();
    add(1, 3'd5, 0, 32'h0,        21'h0,       3'd0, 0);
    add(0, 3'd0, 1, 32'h00001800, 21'h0,       3'd0, 0);
    add(0, 3'd0, 1, 32'h00001FFE, 21'h0,       3'd0, 1);
    add(1, 3'd0, 0, 32'h0,        21'h3,       3'd0, 1);

    // Fill, PLRU eviction, hits on touched ways
    add_rst();
    for (int k = 1; k <= 8; k++)
      add(0, 3'd0, 1, tgt(21'(k), (k == 8) ? 11'h7FF : 11'h0), 21'h0, 3'(k - 1), 0);
    add(0, 3'd0, 1, tgt(21'h9, 11'h0),   21'h0, 3'd0, 0);
    add(1, 3'd0, 0, 32'h0,               21'h9, 3'd0, 0);
    add(0, 3'd0, 1, tgt(21'h9, 11'h123), 21'h9, 3'd0, 1);
    add(0, 3'd0, 1, tgt(21'h2, 11'h0),   21'h9, 3'd1, 1);
    add(0, 3'd0, 1, tgt(21'h3, 11'h0),   21'h9, 3'd2, 1);
    add(0, 3'd0, 1, tgt(21'h4, 11'h0),   21'h9, 3'd3, 1);
    add(0, 3'd0, 1, tgt(21'hA, 11'h0),   21'h9, 3'd4, 0);
    add(0, 3'd0, 1, tgt(21'h1, 11'h0),   21'h9, 3'd0, 0);
    add(0, 3'd0, 1, tgt(21'h1, 11'h7FF), 21'h9, 3'd0, 1);
    add(0, 3'd0, 1, tgt(21'h9, 11'h0),   21'h9, 3'd6, 0);
    add(0, 3'd0, 0, 32'h0,               21'h9, 3'd6, 0);
    add(1, 3'd6, 1, tgt(21'hA, 11'h0),   21'h9, 3'd4, 1);
    add(1, 3'd4, 0, 32'h0,               21'hA, 3'd4, 1);
    add(1, 3'd7, 0, 32'h0,               21'h8, 3'd4, 1);
    add(0, 3'd0, 1, 32'hFFFFFFFF,        21'h8, 3'd2, 0);
    add(1, 3'd2, 0, 32'h0,               21'h1FFFFF, 3'd2, 0);

    // Same-cycle read and miss-allocate to the same index
    add_rst();
    add(0, 3'd0, 1, tgt(21'h1, 11'h0),  21'h0,  3'd0, 0);
    add(0, 3'd0, 1, tgt(21'h2, 11'h0),  21'h0,  3'd1, 0);
    add(1, 3'd2, 1, tgt(21'h55, 11'h0), BYP_RD, 3'd2, 0);
    add(1, 3'd2, 0, 32'h0,              21'h55, 3'd2, 0);

    @(negedge clk);
    step = 0;
    foreach (vecs[i]) begin
      if (vecs[i].kind == K_RST) apply_reset(step);
      else                       apply_cycle(step, vecs[i]);
      step++;
    end

    midstream_reset(step);
    step += 2;
    apply_cycle(step++, '{K_CYC, 1'b1, 3'd2, 1'b0, 32'h0, 21'h0, 3'd0, 1'b0});
    apply_cycle(step++, '{K_CYC, 1'b0, 3'd0, 1'b1, tgt(21'h33, 11'h0), 21'h0, 3'd0, 1'b0});
    apply_cycle(step++, '{K_CYC, 1'b1, 3'd0, 1'b0, 32'h0, 21'h33, 3'd0, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
